// File: rtl/pipe_pkg.sv
// Shared widths, per-boundary register-field counts and control-bit positions for the pipeline stage registers.
// Latency: none (constants only).
// Backpressure: not applicable.
package pipe_pkg;

    // Default datapath widths: payload is pc, data1, data2 and extend at 32 bits each.
    localparam int DATA_W_DEF = 128;
    localparam int CTRL_W_DEF = 10;
    localparam int REG_W_DEF  = 5;
    localparam int CNT_W_DEF  = 16;

    // Register-index fields carried across each stage boundary.
    localparam int REG_CNT_IFID  = 2;  // rs, rt
    localparam int REG_CNT_IDEX  = 4;  // rs, rt, rd, shamt/forwarding source
    localparam int REG_CNT_EXMEM = 2;  // rt, selected destination
    localparam int REG_CNT_MEMWB = 1;  // selected destination

    // Bit positions inside the control field.
    localparam int CTRL_REGDST   = 0;
    localparam int CTRL_ALUSRC   = 1;
    localparam int CTRL_MEMTOREG = 2;
    localparam int CTRL_REGWRITE = 3;
    localparam int CTRL_MEMWRITE = 4;
    localparam int CTRL_EXTOP    = 5;
    localparam int CTRL_ALUOP_LO = 6;
    localparam int CTRL_ALUOP_HI = 7;
    localparam int CTRL_MEMREAD  = 8;

endpackage

// File: rtl/pipe_entry.sv
// One valid+payload storage slot: synchronous reset, clear (drops valid and control) beats load.
// Latency: 1 cycle from load to q outputs.
// Backpressure: none; the owner decides when to load or clear.
module pipe_entry
    import pipe_pkg::*;
#(
    parameter int PAY_W  = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic [PAY_W-1:0]  d_pay,
    input  logic [CTRL_W-1:0] d_ctrl,
    output logic              q_valid,
    output logic [PAY_W-1:0]  q_pay,
    output logic [CTRL_W-1:0] q_ctrl
);

    // Slot register; payload is kept on clear so the datapath bits stay stable under a bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_valid <= 1'b0;
            q_pay   <= '0;
            q_ctrl  <= '0;
        end else if (clear) begin
            q_valid <= 1'b0;
            q_ctrl  <= '0;
        end else if (load) begin
            q_valid <= 1'b1;
            q_pay   <= d_pay;
            q_ctrl  <= d_ctrl;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready, 2-entry skid (main M + skid S), flush and saturating stall counter.
// Latency: 1 cycle from accepted input to out_valid_o when the output is not blocked.
// Backpressure: in_ready_o is registered and low exactly while S holds an entry; stall_i acts as out_ready_i=0.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int CTRL_W  = CTRL_W_DEF,
    parameter int REG_W   = REG_W_DEF,
    parameter int REG_CNT = REG_CNT_IDEX,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [DATA_W-1:0]        in_data_i,
    input  logic [CTRL_W-1:0]        in_ctrl_i,
    input  logic [REG_W*REG_CNT-1:0] in_reg_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [DATA_W-1:0]        out_data_o,
    output logic [CTRL_W-1:0]        out_ctrl_o,
    output logic [REG_W*REG_CNT-1:0] out_reg_o,
    input  logic                     stall_i,
    input  logic                     flush_i,
    output logic [CNT_W-1:0]         stall_cnt_o
);

    localparam int RG_W  = REG_W * REG_CNT;
    localparam int PAY_W = DATA_W + RG_W;

    logic              adv;
    logic              acc;
    logic              m_free;
    logic              m_valid;
    logic [PAY_W-1:0]  m_pay;
    logic [CTRL_W-1:0] m_ctrl;
    logic              s_valid;
    logic [PAY_W-1:0]  s_pay;
    logic [CTRL_W-1:0] s_ctrl;
    logic              m_load;
    logic              m_clear;
    logic              m_from_s;
    logic              s_load;
    logic              s_clear;
    logic              s_valid_nxt;
    logic [PAY_W-1:0]  m_d_pay;
    logic [CTRL_W-1:0] m_d_ctrl;
    logic              ready_q;
    logic [CNT_W-1:0]  cnt_q;

    assign adv    = out_ready_i & ~stall_i;
    assign acc    = in_valid_i & ready_q;
    assign m_free = ~m_valid | adv;

    // Steering: flush kills both slots; a free M refills from S first, else from the input; a blocked M parks input in S.
    always_comb begin
        m_load      = 1'b0;
        m_clear     = 1'b0;
        m_from_s    = 1'b0;
        s_load      = 1'b0;
        s_clear     = 1'b0;
        s_valid_nxt = s_valid;
        if (flush_i) begin
            m_clear     = 1'b1;
            s_clear     = 1'b1;
            s_valid_nxt = 1'b0;
        end else if (m_free) begin
            if (s_valid) begin
                m_load      = 1'b1;
                m_from_s    = 1'b1;
                s_load      = acc;
                s_clear     = ~acc;
                s_valid_nxt = acc;
            end else if (acc) begin
                m_load = 1'b1;
            end else begin
                m_clear = 1'b1;
            end
        end else if (acc) begin
            s_load      = 1'b1;
            s_valid_nxt = 1'b1;
        end
    end

    assign m_d_pay  = m_from_s ? s_pay  : {in_reg_i, in_data_i};
    assign m_d_ctrl = m_from_s ? s_ctrl : in_ctrl_i;

    pipe_entry #(.PAY_W(PAY_W), .CTRL_W(CTRL_W)) u_main (
        .clk     (clk_i),
        .rst_n   (rst_n_i),
        .load    (m_load),
        .clear   (m_clear),
        .d_pay   (m_d_pay),
        .d_ctrl  (m_d_ctrl),
        .q_valid (m_valid),
        .q_pay   (m_pay),
        .q_ctrl  (m_ctrl)
    );

    pipe_entry #(.PAY_W(PAY_W), .CTRL_W(CTRL_W)) u_skid (
        .clk     (clk_i),
        .rst_n   (rst_n_i),
        .load    (s_load),
        .clear   (s_clear),
        .d_pay   ({in_reg_i, in_data_i}),
        .d_ctrl  (in_ctrl_i),
        .q_valid (s_valid),
        .q_pay   (s_pay),
        .q_ctrl  (s_ctrl)
    );

    // Registered ready (S empty after this edge) and saturating count of edges where M is valid but blocked.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            ready_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            ready_q <= ~s_valid_nxt;
            if (m_valid && !adv && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign in_ready_o  = ready_q;
    assign out_valid_o = m_valid;
    assign out_data_o  = m_pay[DATA_W-1:0];
    assign out_reg_o   = m_pay[PAY_W-1:DATA_W];
    assign out_ctrl_o  = m_valid ? m_ctrl : '0;
    assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: queue-based model of the two stored entries plus directed literal expectations.
// Latency: model updates on each rising edge; outputs compared on every falling edge after reset.
// Backpressure: exercised through stall_i, out_ready_i and the registered in_ready_o.
module tb_pipe_stage_reg;

    localparam int DW   = 128;
    localparam int CW   = 10;
    localparam int RW   = 5;
    localparam int RC   = 4;
    localparam int CNW  = 4;
    localparam int RGW  = RW * RC;
    localparam int CMAX = (1 << CNW) - 1;

    typedef struct {
        logic [DW-1:0]  d;
        logic [CW-1:0]  c;
        logic [RGW-1:0] r;
    } ent_t;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [DW-1:0]  in_data;
    logic [CW-1:0]  in_ctrl;
    logic [RGW-1:0] in_reg;
    logic           out_valid;
    logic           out_ready;
    logic [DW-1:0]  out_data;
    logic [CW-1:0]  out_ctrl;
    logic [RGW-1:0] out_reg;
    logic           stall;
    logic           flush;
    logic [CNW-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    ent_t mq[$];
    bit   mrdy = 1'b1;
    int   mcnt = 0;
    bit   mon  = 1'b0;
    bit   madv;
    bit   macc;

    pipe_stage_reg #(
        .DATA_W (DW),
        .CTRL_W (CW),
        .REG_W  (RW),
        .REG_CNT(RC),
        .CNT_W  (CNW)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .in_ctrl_i   (in_ctrl),
        .in_reg_i    (in_reg),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_ctrl_o  (out_ctrl),
        .out_reg_o   (out_reg),
        .stall_i     (stall),
        .flush_i     (flush),
        .stall_cnt_o (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pd(input int v);
        logic [31:0] w;
        w = 32'(v);
        return {w, ~w, w ^ 32'h5A5A_0000, w + 32'd1};
    endfunction

    function automatic logic [CW-1:0] pc(input int v);
        return CW'(v * 3 + 1);
    endfunction

    function automatic logic [RGW-1:0] pr(input int v);
        return RGW'(v * 37 + 5);
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input bit vld, input int v);
        in_valid = vld;
        in_data  = pd(v);
        in_ctrl  = pc(v);
        in_reg   = pr(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: stored entries are a FIFO of at most two; ready means at most one entry remains after the edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            mq.delete();
            mrdy = 1'b1;
            mcnt = 0;
            mon  = 1'b1;
        end else if (mon) begin
            madv = out_ready && !stall;
            macc = in_valid && mrdy;
            if (mq.size() > 0 && !madv && mcnt < CMAX) mcnt++;
            if (flush) begin
                mq.delete();
            end else begin
                if (mq.size() > 0 && madv) void'(mq.pop_front());
                if (macc) mq.push_back('{d: in_data, c: in_ctrl, r: in_reg});
            end
            mrdy = (mq.size() <= 1);
        end
    end

    // Compare every cycle once the model has seen reset.
    always @(negedge clk) begin
        if (mon) begin
            chk("m_out_valid", out_valid, mq.size() > 0);
            chk("m_in_ready", in_ready, mrdy);
            chk("m_stall_cnt", stall_cnt, mcnt);
            chk("m_out_ctrl", out_ctrl, (mq.size() > 0) ? mq[0].c : '0);
            if (mq.size() > 0) begin
                chk("m_out_data", out_data, mq[0].d);
                chk("m_out_reg", out_reg, mq[0].r);
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'($urandom);
        in_data   = {$urandom, $urandom, $urandom, $urandom};
        in_ctrl   = CW'($urandom);
        in_reg    = RGW'($urandom);
        out_ready = 1'($urandom);
        stall     = 1'($urandom);
        flush     = 1'($urandom);

        // Reset with random inputs.
        repeat (2) step();
        chk("rst_valid", out_valid, 0);
        chk("rst_ctrl", out_ctrl, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_cnt", stall_cnt, 0);
        rst_n = 1'b1; out_ready = 1'b1; stall = 1'b0; flush = 1'b0;
        drive(0, 0);
        step();

        // Streaming 1..8 with no backpressure.
        for (int v = 1; v <= 8; v++) begin
            drive(1, v);
            step();
            chk("stream_data", out_data, pd(v));
            chk("stream_ready", in_ready, 1);
        end
        drive(0, 0);
        step();
        chk("stream_drained", out_valid, 0);

        // Stall with skid: A held, B into S, C waits upstream.
        drive(1, 'hA);
        step();
        stall = 1'b1;
        drive(1, 'hB);
        step();
        chk("skid_ready_low", in_ready, 0);
        drive(1, 'hC);
        step();
        step();
        chk("skid_cnt", stall_cnt, 3);
        chk("skid_hold_a", out_data, pd('hA));
        stall = 1'b0;
        step();
        chk("skid_out_b", out_data, pd('hB));
        chk("skid_ready_back", in_ready, 1);
        step();
        chk("skid_out_c", out_data, pd('hC));
        drive(0, 0);
        step();
        chk("skid_drained", out_valid, 0);

        // Flush during stall with M and S full and a new input presented.
        drive(1, 'h1A);
        step();
        stall = 1'b1;
        drive(1, 'h1B);
        step();
        flush = 1'b1;
        drive(1, 'hD);
        step();
        chk("flush_valid", out_valid, 0);
        chk("flush_ctrl", out_ctrl, 0);
        chk("flush_ready", in_ready, 1);
        flush = 1'b0; stall = 1'b0;
        drive(0, 0);
        step();
        step();
        chk("flush_no_emit", out_valid, 0);
        chk("flush_cnt", stall_cnt, 5);

        // Reset while S is full.
        drive(1, 'h2A);
        step();
        stall = 1'b1;
        drive(1, 'h2B);
        step();
        chk("mrst_s_full", in_ready, 0);
        drive(1, 'h2C);
        rst_n = 1'b0;
        step();
        chk("mrst_valid", out_valid, 0);
        chk("mrst_ready", in_ready, 1);
        chk("mrst_cnt", stall_cnt, 0);
        rst_n = 1'b1; stall = 1'b0;
        drive(1, 'hE);
        step();
        chk("mrst_first_new", out_data, pd('hE));
        chk("mrst_first_valid", out_valid, 1);
        drive(0, 0);
        step();
        chk("mrst_alone", out_valid, 0);

        // Counter saturation: 10 cycles of stall_i, then 10 of out_ready_i low.
        drive(1, 'hF);
        step();
        drive(0, 0);
        stall = 1'b1;
        repeat (10) step();
        chk("sat_cnt_10", stall_cnt, 10);
        stall = 1'b0; out_ready = 1'b0;
        repeat (10) step();
        chk("sat_cnt_15", stall_cnt, 15);
        step();
        chk("sat_cnt_hold", stall_cnt, 15);
        chk("sat_data_held", out_data, pd('hF));
        out_ready = 1'b1;
        step();
        chk("sat_drained", out_valid, 0);
        chk("sat_cnt_kept", stall_cnt, 15);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
